// File: rtl/cam_pkg.sv
// Shared sizing, reserved scrub key and controller state encoding for the CAM lookup controller.
package cam_pkg;

  localparam int NB_MEM          = 16;
  localparam int SIZE_ADDR       = 4;
  localparam logic [7:0] SCRUB_KEY = 8'hFF;

  typedef enum logic [2:0] {
    SCRUB,
    IDLE,
    SEARCH,
    CHECK,
    WRITE,
    RESP
  } state_t;

endpackage

// File: rtl/cam_free_prienc.sv
// Lowest-free-slot finder over the entry-valid vector; purely combinational.
// full is high when every entry is valid, in which case alloc is 0.
module cam_free_prienc
  import cam_pkg::*;
(
  input  logic [NB_MEM-1:0]    valid,
  output logic [SIZE_ADDR-1:0] alloc,
  output logic                 full
);

  // Scan from the top down so the lowest clear bit is the last one assigned.
  always_comb begin
    alloc = '0;
    full  = 1'b1;
    for (int i = NB_MEM - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        alloc = SIZE_ADDR'(i);
        full  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_lookup_ctrl.sv
// Sequences CAM search/learn for one key at a time; response 1 (reserved key), 3 (hit/miss) or 4 (learn) cycles after accept.
// One request in flight: req_ready stays low until the response is taken with rsp_ready.
module cam_lookup_ctrl
  import cam_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_key,
  input  logic                 req_learn,
  input  logic                 flush,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic                 rsp_new,
  output logic                 rsp_full,
  output logic [SIZE_ADDR-1:0] rsp_idx,
  output logic                 cam_enable,
  output logic                 cam_write,
  output logic [4:0]           cam_addr,
  output logic [7:0]           cam_data,
  input  logic [4:0]           cam_out,
  input  logic                 cam_found
);

  state_t                state;
  logic [SIZE_ADDR-1:0]  scrub_cnt;
  logic [NB_MEM-1:0]     valid;
  logic [7:0]            key_q;
  logic                  learn_q;
  logic [SIZE_ADDR-1:0]  alloc;
  logic                  tbl_full;
  logic                  hit;
  logic                  unused_cam_msb;

  cam_free_prienc u_prienc (
    .valid (valid),
    .alloc (alloc),
    .full  (tbl_full)
  );

  // The CAM reports a match even for stale entries, so the valid bit qualifies it.
  assign hit            = cam_found && valid[cam_out[SIZE_ADDR-1:0]];
  assign unused_cam_msb = cam_out[4];

  assign req_ready  = (state == IDLE) && !flush;
  assign cam_enable = (state == SEARCH);
  assign cam_write  = (state == SCRUB) || (state == WRITE);

  always_comb begin
    cam_addr = 5'd0;
    cam_data = key_q;
    case (state)
      SCRUB: begin
        cam_addr = {1'b0, scrub_cnt};
        cam_data = SCRUB_KEY;
      end
      WRITE:   cam_addr = {1'b0, alloc};
      default: cam_addr = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCRUB;
      scrub_cnt <= '0;
      valid     <= '0;
      key_q     <= '0;
      learn_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_new   <= 1'b0;
      rsp_full  <= 1'b0;
      rsp_idx   <= '0;
    end else begin
      case (state)
        SCRUB: begin
          scrub_cnt <= scrub_cnt + 1'b1;
          if (scrub_cnt == SIZE_ADDR'(NB_MEM - 1)) state <= IDLE;
        end
        IDLE: begin
          if (flush) begin
            valid     <= '0;
            scrub_cnt <= '0;
            state     <= SCRUB;
          end else if (req_valid) begin
            key_q   <= req_key;
            learn_q <= req_learn;
            // The reserved key fills every scrubbed slot, so it is never searched.
            if (req_key == SCRUB_KEY) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= SEARCH;
            end
          end
        end
        SEARCH: state <= CHECK;
        CHECK: begin
          if (hit) begin
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b1;
            rsp_idx   <= cam_out[SIZE_ADDR-1:0];
            state     <= RESP;
          end else if (learn_q && !tbl_full) begin
            state <= WRITE;
          end else begin
            rsp_valid <= 1'b1;
            rsp_full  <= learn_q;
            state     <= RESP;
          end
        end
        WRITE: begin
          valid[alloc] <= 1'b1;
          rsp_valid    <= 1'b1;
          rsp_new      <= 1'b1;
          rsp_idx      <= alloc;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_new   <= 1'b0;
            rsp_full  <= 1'b0;
            rsp_idx   <= '0;
            state     <= IDLE;
          end
        end
        default: state <= SCRUB;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Directed bench for cam_lookup_ctrl driving a behavioural 16-entry CAM
// (combinational OR-of-indices match, registered found flag).
module tb_cam_lookup_ctrl;
  import cam_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_key = 8'h00;
  logic       req_learn = 1'b0;
  logic       flush = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_hit, rsp_new, rsp_full;
  logic [3:0] rsp_idx;
  logic       cam_enable, cam_write;
  logic [4:0] cam_addr;
  logic [7:0] cam_data;
  logic [4:0] cam_out;
  logic       cam_found;

  always #5 clk = ~clk;

  cam_lookup_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_key    (req_key),
    .req_learn  (req_learn),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_hit    (rsp_hit),
    .rsp_new    (rsp_new),
    .rsp_full   (rsp_full),
    .rsp_idx    (rsp_idx),
    .cam_enable (cam_enable),
    .cam_write  (cam_write),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .cam_out    (cam_out),
    .cam_found  (cam_found)
  );

  // Behavioural CAM
  logic [7:0] cam_mem [16];
  logic       cam_any;

  always_comb begin
    cam_out = 5'd0;
    cam_any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (cam_mem[i] === cam_data) begin
        cam_out = cam_out | 5'(i);
        cam_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cam_write) cam_mem[cam_addr[3:0]] <= cam_data;
    if (cam_enable) cam_found <= cam_any;
  end

  int checks = 0;
  int errors = 0;

  int         lat;
  logic       r_hit, r_new, r_full, saw_en, saw_wr;
  logic [3:0] r_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a post-edge point; returns latency in cycles
  // (accept edge = cycle 0, first post-accept cycle = 1) and the response.
  task automatic do_req(input logic [7:0] key, input logic learn, input logic ack);
    int guard;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("req_ready_wait", 32'(guard < 100), 32'd1);
    req_valid = 1'b1;
    req_key   = key;
    req_learn = learn;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat    = 1;
    saw_en = 1'b0;
    saw_wr = 1'b0;
    while (!rsp_valid && lat < 20) begin
      saw_en = saw_en | cam_enable;
      saw_wr = saw_wr | cam_write;
      @(posedge clk); #1;
      lat++;
    end
    r_hit  = rsp_hit;
    r_new  = rsp_new;
    r_full = rsp_full;
    r_idx  = rsp_idx;
    if (ack) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;

    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cam_write", cam_write, 1);
    chk("rst_cam_enable", cam_enable, 0);
    chk("rst_cam_addr", cam_addr, 0);
    chk("rst_cam_data", cam_data, 8'hFF);

    // Scrub sequence after reset release
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (!(cam_write === 1'b1 && cam_addr === 5'(i) && cam_data === 8'hFF && req_ready === 1'b0))
        bad++;
      @(posedge clk); #1;
    end
    chk("scrub_seq", bad, 0);
    chk("ready_after_scrub", req_ready, 1);

    // Plain miss on an empty table
    do_req(8'h3C, 1'b0, 1'b1);
    chk("miss_lat", lat, 3);
    chk("miss_flags", {r_hit, r_new, r_full, r_idx}, 7'h00);
    chk("miss_no_write", saw_wr, 0);
    chk("miss_enable", saw_en, 1);

    // Learn three keys into slots 0..2
    do_req(8'h10, 1'b1, 1'b1);
    chk("learn10_lat", lat, 4);
    chk("learn10", {r_hit, r_new, r_full, r_idx}, {3'b010, 4'd0});
    chk("learn10_write", saw_wr, 1);
    do_req(8'h20, 1'b1, 1'b1);
    chk("learn20", {r_hit, r_new, r_full, r_idx}, {3'b010, 4'd1});
    do_req(8'h30, 1'b1, 1'b1);
    chk("learn30", {r_hit, r_new, r_full, r_idx}, {3'b010, 4'd2});

    // Hit on a learned key; learn flag must not cause a write on a hit
    do_req(8'h20, 1'b1, 1'b1);
    chk("hit20_lat", lat, 3);
    chk("hit20", {r_hit, r_new, r_full, r_idx}, {3'b100, 4'd1});
    chk("hit20_no_write", saw_wr, 0);

    // Fill remaining 13 slots
    for (int i = 0; i < 13; i++) begin
      do_req(8'h40 + 8'(i), 1'b1, 1'b1);
      chk("fill", {r_hit, r_new, r_full, r_idx}, {3'b010, 4'(3 + i)});
    end

    // Table full
    do_req(8'hA5, 1'b1, 1'b1);
    chk("full_lat", lat, 3);
    chk("full_flags", {r_hit, r_new, r_full, r_idx}, {3'b001, 4'd0});
    chk("full_no_write", saw_wr, 0);
    do_req(8'h4C, 1'b0, 1'b1);
    chk("hit_last", {r_hit, r_new, r_full, r_idx}, {3'b100, 4'd15});

    // Reserved key never touches the CAM
    do_req(8'hFF, 1'b1, 1'b1);
    chk("rsvd_lat", lat, 1);
    chk("rsvd_flags", {r_hit, r_new, r_full, r_idx}, 7'h00);
    chk("rsvd_cam_idle", {saw_en, saw_wr}, 2'b00);

    // Response held under backpressure
    do_req(8'h30, 1'b0, 1'b0);
    chk("hold_first", {rsp_valid, r_hit, r_idx}, {2'b11, 4'd2});
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (!(rsp_valid === 1'b1 && rsp_hit === 1'b1 && rsp_new === 1'b0 &&
            rsp_full === 1'b0 && rsp_idx === 4'd2 && req_ready === 1'b0))
        bad++;
    end
    chk("hold_stable", bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_dropped", rsp_valid, 0);
    chk("ready_after_rsp", req_ready, 1);

    // Flush wins over a simultaneous request
    flush     = 1'b1;
    req_valid = 1'b1;
    req_key   = 8'h10;
    req_learn = 1'b0;
    #1;
    chk("flush_ready_low", req_ready, 0);
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_scrub", {cam_write, cam_addr, cam_data}, {1'b1, 5'd0, 8'hFF});
    chk("flush_no_rsp", rsp_valid, 0);

    // Previously learned key now misses; table allocates from slot 0 again
    do_req(8'h10, 1'b0, 1'b1);
    chk("post_flush_miss", {r_hit, r_new, r_full, r_idx}, 7'h00);
    chk("post_flush_lat", lat, 3);
    do_req(8'h55, 1'b1, 1'b1);
    chk("post_flush_learn", {r_hit, r_new, r_full, r_idx}, {3'b010, 4'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
